// File: rtl/regbank_pkg.sv
// Shared register-bank definitions: widths, register count and the
// write-back arbiter preference states.
package regbank_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 2 ** ADDR_W;

    // Which requester wins when both ask in the same cycle.
    typedef enum logic {
        PREF_ALU = 1'b0,
        PREF_MEM = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester alternating-priority arbiter.
// Bit 0 is the ALU requester, bit 1 is the load requester.
// The grant is combinational from the requests and the held preference.
module rr_arbiter2
    import regbank_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] request,
    output logic [1:0] grant
);

    arb_state_t state_reg;
    arb_state_t state_next;

    // Preference register; reset makes the ALU the first favourite.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= PREF_ALU;
        end else begin
            state_reg <= state_next;
        end
    end

    // Hand the preference to the requester that did not just win.
    always_comb begin
        state_next = state_reg;
        if (grant[0]) begin
            state_next = PREF_MEM;
        end else if (grant[1]) begin
            state_next = PREF_ALU;
        end
    end

    // A lone request is always granted; a tie goes to the favourite.
    always_comb begin
        grant = 2'b00;
        case (request)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (state_reg == PREF_ALU) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Register-file write-back scheduler: arbitrates ALU and load results onto
// the single bank write port (one-cycle latency), tracks pending
// destinations in a busy scoreboard and flags read-after-write hazards.
module regfile_write_scheduler #(
    parameter int DATA_W = regbank_pkg::DATA_W,
    parameter int ADDR_W = regbank_pkg::ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic              stall,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] dataToWrite,
    output logic [15:0]       write_count
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [1:0]        request;
    logic [1:0]        grant;
    logic              xfer;
    logic [ADDR_W-1:0] xfer_rd;
    logic [DATA_W-1:0] xfer_data;

    logic              regwrite_reg;
    logic [ADDR_W-1:0] rd_reg;
    logic [DATA_W-1:0] data_reg;
    logic [15:0]       count_reg;
    logic [NREGS-1:0]  busy;

    // Requests are masked during reset so neither channel sees ready.
    assign request = {mem_valid, alu_valid} & {2{~reset}};

    rr_arbiter2 u_arb (
        .clock   (clock),
        .reset   (reset),
        .request (request),
        .grant   (grant)
    );

    assign alu_ready = grant[0];
    assign mem_ready = grant[1];
    assign xfer      = (alu_valid & alu_ready) | (mem_valid & mem_ready);
    assign xfer_rd   = alu_ready ? alu_rd   : mem_rd;
    assign xfer_data = alu_ready ? alu_data : mem_data;

    // Bank write port: register the accepted transfer; rd/data hold when idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            regwrite_reg <= 1'b0;
            rd_reg       <= '0;
            data_reg     <= '0;
        end else begin
            regwrite_reg <= xfer;
            if (xfer) begin
                rd_reg   <= xfer_rd;
                data_reg <= xfer_data;
            end
        end
    end

    // Completed-write counter; advances at the end of every write cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_reg <= 16'd0;
        end else if (regwrite_reg) begin
            count_reg <= count_reg + 16'd1;
        end
    end

    // Busy scoreboard, one bit per register; a new issue beats a retire.
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_busy
            logic set_hit;
            logic clr_hit;
            logic bit_reg;

            assign set_hit = issue_valid && (issue_rd == ADDR_W'(gi));
            assign clr_hit = xfer && (xfer_rd == ADDR_W'(gi));

            // Set on issue, clear on write-back transfer, set dominates.
            always_ff @(posedge clock) begin
                if (reset) begin
                    bit_reg <= 1'b0;
                end else if (set_hit) begin
                    bit_reg <= 1'b1;
                end else if (clr_hit) begin
                    bit_reg <= 1'b0;
                end
            end

            assign busy[gi] = bit_reg;
        end
    endgenerate

    // Hazard lookup straight from the registered scoreboard (no bypass).
    assign stall       = busy[rs] | busy[rt];

    assign RegWrite    = regwrite_reg;
    assign rd          = rd_reg;
    assign dataToWrite = data_reg;
    assign write_count = count_reg;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Scoreboard bench for regfile_write_scheduler: the stimulus side drives
// directed and random traffic, a reference model queues expected writes at
// each clock edge, and a monitor compares the DUT on the falling edge.
module tb_regfile_write_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic        alu_valid, mem_valid, issue_valid;
    logic        alu_ready, mem_ready;
    logic [2:0]  alu_rd, mem_rd, issue_rd, rs, rt;
    logic [15:0] alu_data, mem_data;
    logic        stall, RegWrite;
    logic [2:0]  rd;
    logic [15:0] dataToWrite;
    logic [15:0] write_count;

    regfile_write_scheduler #(.DATA_W(16), .ADDR_W(3)) dut (
        .clock       (clock),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs          (rs),
        .rt          (rt),
        .stall       (stall),
        .RegWrite    (RegWrite),
        .rd          (rd),
        .dataToWrite (dataToWrite),
        .write_count (write_count)
    );

    always #5 clock = ~clock;

    int checks  = 0;
    int errors  = 0;
    bit verbose = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [2:0]  rd;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_q[$];
    bit          m_busy[8];
    bit          m_favour_alu = 1'b1;
    bit          m_write_due  = 1'b0;
    int          m_count      = 0;
    logic [2:0]  m_last_rd    = '0;
    logic [15:0] m_last_data  = '0;

    // Who should win this cycle, from the current inputs and the favourite.
    function automatic void exp_grant(output bit ga, output bit gm);
        ga = 1'b0;
        gm = 1'b0;
        if (!reset) begin
            if (alu_valid && mem_valid) begin
                ga = m_favour_alu;
                gm = !m_favour_alu;
            end else begin
                ga = alu_valid;
                gm = mem_valid;
            end
        end
    endfunction

    // Model state advances on the same edge as the DUT.
    always @(posedge clock) begin
        bit ga, gm;
        exp_grant(ga, gm);
        if (reset) begin
            exp_q.delete();
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_favour_alu = 1'b1;
            m_write_due  = 1'b0;
            m_count      = 0;
            m_last_rd    = '0;
            m_last_data  = '0;
        end else begin
            if (m_write_due) m_count = (m_count + 1) % 65536;
            m_write_due = ga || gm;
            if (ga) begin
                exp_q.push_back('{rd: alu_rd, data: alu_data});
                m_busy[alu_rd] = 1'b0;
                m_favour_alu   = 1'b0;
            end else if (gm) begin
                exp_q.push_back('{rd: mem_rd, data: mem_data});
                m_busy[mem_rd] = 1'b0;
                m_favour_alu   = 1'b1;
            end
            if (issue_valid) m_busy[issue_rd] = 1'b1;
        end
    end

    // Monitor: compare handshakes, hazard flag, counter and write port.
    always @(negedge clock) begin
        bit  ga, gm;
        wr_t w;
        exp_grant(ga, gm);
        chk("alu_xfer", 32'(alu_valid && alu_ready), 32'(ga));
        chk("mem_xfer", 32'(mem_valid && mem_ready), 32'(gm));
        if (reset) begin
            chk("alu_ready_in_reset", 32'(alu_ready), 32'd0);
            chk("mem_ready_in_reset", 32'(mem_ready), 32'd0);
        end
        chk("stall", 32'(stall), 32'(m_busy[rs] | m_busy[rt]));
        chk("write_count", 32'(write_count), 32'(m_count));
        if (RegWrite) begin
            if (exp_q.size() == 0) begin
                chk("RegWrite_unexpected", 32'(RegWrite), 32'd0);
            end else begin
                w = exp_q.pop_front();
                chk("wr_rd", 32'(rd), 32'(w.rd));
                chk("wr_data", 32'(dataToWrite), 32'(w.data));
                m_last_rd   = w.rd;
                m_last_data = w.data;
                if (verbose)
                    $display("write rd=%0d data=0x%04h count=%0d t=%0t", rd, dataToWrite, write_count, $time);
            end
        end else begin
            if (exp_q.size() != 0) begin
                chk("RegWrite_missing", 32'(RegWrite), 32'd1);
                void'(exp_q.pop_front());
            end
            chk("rd_hold", 32'(rd), 32'(m_last_rd));
            chk("data_hold", 32'(dataToWrite), 32'(m_last_data));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic av, input logic [2:0] ard, input logic [15:0] adat,
                         input logic mv, input logic [2:0] mrd, input logic [15:0] mdat,
                         input logic iv, input logic [2:0] ird,
                         input logic [2:0] rsv, input logic [2:0] rtv, input logic rst);
        @(posedge clock);
        #1;
        alu_valid = av;  alu_rd = ard;  alu_data = adat;
        mem_valid = mv;  mem_rd = mrd;  mem_data = mdat;
        issue_valid = iv; issue_rd = ird;
        rs = rsv; rt = rtv; reset = rst;
    endtask

    task automatic idle(input logic rst);
        drive(0, 0, 16'h0, 0, 0, 16'h0, 0, 0, 0, 0, rst);
    endtask

    initial begin
        bit acc_a, acc_m;
        reset = 1'b1;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0;
        issue_valid = 0; issue_rd = 0; rs = 0; rt = 0;

        idle(1); idle(1);
        // Reset state
        idle(0);
        @(negedge clock);
        chk("rst_RegWrite", 32'(RegWrite), 32'd0);
        chk("rst_rd", 32'(rd), 32'd0);
        chk("rst_data", 32'(dataToWrite), 32'd0);
        chk("rst_count", 32'(write_count), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);

        // Single ALU write, one-cycle latency
        drive(1, 3'd3, 16'h1234, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("alu_only_ready", 32'(alu_ready), 32'd1);
        idle(0);
        @(negedge clock);
        chk("alu_only_RegWrite", 32'(RegWrite), 32'd1);
        chk("alu_only_rd", 32'(rd), 32'd3);
        chk("alu_only_data", 32'(dataToWrite), 32'h1234);
        idle(0);
        @(negedge clock);
        chk("alu_only_count", 32'(write_count), 32'd1);

        // Both channels valid for four cycles: ALU, MEM, ALU, MEM
        idle(1);
        for (int k = 0; k < 4; k++) begin
            drive(1, 3'(k), 16'(16'hA000 + k), 1, 3'(k + 4), 16'(16'hB000 + k), 0, 0, 0, 0, 0);
            @(negedge clock);
            chk("alt_alu_ready", 32'(alu_ready), 32'((k % 2) == 0));
            chk("alt_mem_ready", 32'(mem_ready), 32'((k % 2) == 1));
            if (k > 0) chk("alt_RegWrite", 32'(RegWrite), 32'd1);
        end
        idle(0);
        @(negedge clock);
        chk("alt_RegWrite_last", 32'(RegWrite), 32'd1);

        // Hazard on rd=5
        idle(1);
        drive(0, 0, 0, 0, 0, 0, 1, 3'd5, 3'd5, 3'd2, 0);
        @(negedge clock);
        chk("haz_no_bypass", 32'(stall), 32'd0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 3'd5, 3'd5, 0);
            @(negedge clock);
            chk("haz_stall", 32'(stall), 32'd1);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 3'd2, 0);
        @(negedge clock);
        chk("haz_rt2_only", 32'(stall), 32'd0);
        drive(1, 3'd5, 16'h5555, 0, 0, 0, 0, 0, 3'd5, 3'd5, 0);
        @(negedge clock);
        chk("haz_stall_xfer_cycle", 32'(stall), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 3'd5, 3'd5, 0);
        @(negedge clock);
        chk("haz_cleared", 32'(stall), 32'd0);

        // Issue and retire to rd=4 in the same cycle: set wins
        idle(1);
        drive(0, 0, 0, 1, 3'd4, 16'h4444, 1, 3'd4, 3'd4, 3'd4, 0);
        @(negedge clock);
        chk("setwin_mem_ready", 32'(mem_ready), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 3'd4, 3'd4, 0);
        @(negedge clock);
        chk("setwin_stall", 32'(stall), 32'd1);
        chk("setwin_RegWrite", 32'(RegWrite), 32'd1);
        chk("setwin_rd", 32'(rd), 32'd4);

        // Reset coinciding with an ALU request
        idle(1);
        drive(1, 3'd2, 16'h2222, 0, 0, 0, 1, 3'd6, 0, 0, 0);
        drive(1, 3'd7, 16'h7777, 0, 0, 0, 0, 0, 3'd6, 3'd6, 1);
        @(negedge clock);
        chk("rstmid_alu_ready", 32'(alu_ready), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 3'd6, 3'd2, 0);
        @(negedge clock);
        chk("rstmid_RegWrite", 32'(RegWrite), 32'd0);
        chk("rstmid_stall", 32'(stall), 32'd0);
        drive(1, 3'd1, 16'h0101, 1, 3'd2, 16'h0202, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("rstmid_pref_alu", 32'(alu_ready), 32'd1);
        idle(0);

        // Randomized traffic; requesters hold rd/data until accepted
        for (int n = 0; n < 1500; n++) begin
            @(negedge clock);
            acc_a = alu_valid && alu_ready;
            acc_m = mem_valid && mem_ready;
            @(posedge clock);
            #1;
            if (!alu_valid || acc_a) begin
                alu_valid = ($urandom_range(0, 2) != 0);
                alu_rd    = 3'($urandom);
                alu_data  = 16'($urandom);
            end
            if (!mem_valid || acc_m) begin
                mem_valid = ($urandom_range(0, 2) != 0);
                mem_rd    = 3'($urandom);
                mem_data  = 16'($urandom);
            end
            issue_valid = ($urandom_range(0, 3) == 0);
            issue_rd    = 3'($urandom);
            rs          = 3'($urandom);
            rt          = 3'($urandom);
            reset       = ($urandom_range(0, 99) == 0);
        end

        // Counter wrap: 65536 writes bring write_count back to zero
        verbose = 1'b0;
        idle(1);
        for (int i = 0; i < 65536; i++) begin
            drive(1, 3'(i), 16'(i), 0, 0, 0, 0, 0, 0, 0, 0);
        end
        idle(0);
        @(negedge clock);
        chk("wrap_ffff", 32'(write_count), 32'hFFFF);
        idle(0);
        @(negedge clock);
        chk("wrap_zero", 32'(write_count), 32'h0000);
        verbose = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
